// File: rtl/bp_profiler_pkg.sv
// Types and constants shared by the profiler snapshot streamer and its helpers.
package bp_profiler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        STREAM = 2'd2
    } bp_profiler_snapshot_state_e;

    typedef struct packed {
        logic [7:0]  magic;
        logic [7:0]  count;
        logic [15:0] seq;
    } bp_profiler_header_t;

    localparam logic [7:0] bp_profiler_magic_gp = 8'hA5;

    function automatic bp_profiler_header_t make_header(input logic [7:0] count, input logic [15:0] seq);
        bp_profiler_header_t hdr;
        hdr.magic = bp_profiler_magic_gp;
        hdr.count = count;
        hdr.seq   = seq;
        return hdr;
    endfunction

endpackage

// File: rtl/bp_profiler_interval_timer.sv
// Free-running period timer that pulses tick_o once every interval_i enabled cycles.
module bp_profiler_interval_timer #(
    parameter int interval_width_p = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        en_i,
    input  logic [interval_width_p-1:0] interval_i,
    output logic                        tick_o
);

    logic [interval_width_p-1:0] timer_r;
    logic                        active_s;
    logic                        hit_s;

    assign active_s = en_i & (interval_i != {interval_width_p{1'b0}});
    // A period shortened below the current count fires on the next cycle.
    assign hit_s    = (timer_r >= (interval_i - interval_width_p'(1'b1)));
    assign tick_o   = active_s & hit_s;

    // Count while active, restart on tick, otherwise hold.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            timer_r <= {interval_width_p{1'b0}};
        end else if (tick_o) begin
            timer_r <= {interval_width_p{1'b0}};
        end else if (active_s) begin
            timer_r <= timer_r + interval_width_p'(1'b1);
        end else begin
            timer_r <= timer_r;
        end
    end

endmodule

// File: rtl/bsg_dff_en.sv
// Enabled register bank without reset; holds the captured counter snapshot.
module bsg_dff_en #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_r;

    // Load the whole word only when enabled.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            data_r <= data_i;
        end
    end

    assign data_o = data_r;

endmodule

// File: rtl/bp_profiler_snapshot.sv
// Captures the profiler counter array atomically and streams it as a header
// plus els_p words over a valid/ready link.
module bp_profiler_snapshot
    import bp_profiler_pkg::*;
#(
    parameter int width_p          = 32,
    parameter int els_p            = 75,
    parameter int interval_width_p = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          en_i,
    input  logic [els_p-1:0][width_p-1:0] data_i,
    input  logic                          trigger_i,
    input  logic [interval_width_p-1:0]   interval_i,
    output logic                          v_o,
    output logic [width_p-1:0]            data_o,
    input  logic                          ready_i,
    output logic                          busy_o,
    output logic [15:0]                   seq_o,
    output logic [width_p-1:0]            drop_count_o
);

    localparam int                      idx_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [idx_width_lp-1:0] idx_last_lp  = idx_width_lp'(els_p - 1);
    localparam logic [7:0]              count_lp     = 8'(els_p);

    bp_profiler_snapshot_state_e state_r, state_s;
    logic [idx_width_lp-1:0]     idx_r, idx_s;
    logic [15:0]                 seq_r, seq_s;
    logic [width_p-1:0]          drop_r, drop_s;
    logic                        v_r;
    logic [width_p-1:0]          data_r, data_s;
    logic                        tick_s, trig_s, capture_s, handshake_s;
    logic [els_p-1:0][width_p-1:0] shadow_s;

    bp_profiler_interval_timer #(
        .interval_width_p(interval_width_p)
    ) timer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .en_i      (en_i),
        .interval_i(interval_i),
        .tick_o    (tick_s)
    );

    assign trig_s      = en_i & (trigger_i | tick_s);
    assign capture_s   = (state_r == IDLE) & trig_s;
    assign handshake_s = v_r & ready_i;

    bsg_dff_en #(
        .width_p(els_p * width_p)
    ) shadow (
        .clk_i (clk_i),
        .en_i  (capture_s),
        .data_i(data_i),
        .data_o(shadow_s)
    );

    // Next-state, beat index, packet sequence and drop counter.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        seq_s   = seq_r;
        case (state_r)
            IDLE: begin
                if (capture_s) begin
                    state_s = HEADER;
                    idx_s   = {idx_width_lp{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            HEADER: begin
                if (handshake_s) begin
                    state_s = STREAM;
                end else begin
                    state_s = HEADER;
                end
            end
            STREAM: begin
                if (handshake_s && (idx_r == idx_last_lp)) begin
                    state_s = IDLE;
                    seq_s   = seq_r + 16'd1;
                end else if (handshake_s) begin
                    idx_s   = idx_r + idx_width_lp'(1'b1);
                end else begin
                    state_s = STREAM;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (trig_s && (state_r != IDLE) && (drop_r != {width_p{1'b1}})) begin
            drop_s = drop_r + width_p'(1'b1);
        end else begin
            drop_s = drop_r;
        end
    end

    // Output word for the upcoming cycle, so data_o can be a flop.
    always_comb begin
        data_s = {width_p{1'b0}};
        case (state_s)
            IDLE:    data_s = {width_p{1'b0}};
            HEADER:  data_s = width_p'(make_header(count_lp, seq_s));
            STREAM:  data_s = shadow_s[idx_s];
            default: data_s = {width_p{1'b0}};
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            idx_r   <= {idx_width_lp{1'b0}};
            seq_r   <= 16'd0;
            drop_r  <= {width_p{1'b0}};
            v_r     <= 1'b0;
            data_r  <= {width_p{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            seq_r   <= seq_s;
            drop_r  <= drop_s;
            v_r     <= (state_s != IDLE);
            data_r  <= data_s;
        end
    end

    assign v_o          = v_r;
    assign data_o       = data_r;
    assign busy_o       = (state_r != IDLE);
    assign seq_o        = seq_r;
    assign drop_count_o = drop_r;

endmodule

// File: tb/tb_bp_profiler_snapshot.sv
// Self-checking bench for bp_profiler_snapshot: queue-based packet model plus directed and random stimulus.
module tb_bp_profiler_snapshot;

    localparam int W   = 32;
    localparam int ELS = 75;
    localparam int IW  = 32;

    logic                  clk = 1'b0;
    logic                  reset_i = 1'b1;
    logic                  en_i, trigger_i, ready_i;
    logic [ELS-1:0][W-1:0] data_in;
    logic [IW-1:0]         interval_i;
    logic                  v_o, busy_o;
    logic [W-1:0]          data_o, drop_count_o;
    logic [15:0]           seq_o;

    int checks = 0;
    int errors = 0;

    // Model: words still owed to the consumer, packet count, drop count, timer.
    logic [W-1:0] mq[$];
    logic [15:0]  m_seq = 16'd0;
    logic [W-1:0] m_drop = '0;
    longint       m_tmr = 0;
    logic [W-1:0] beats[$];

    always #5 clk = ~clk;

    bp_profiler_snapshot #(.width_p(W), .els_p(ELS), .interval_width_p(IW)) dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .data_i(data_in),
        .trigger_i(trigger_i), .interval_i(interval_i), .v_o(v_o), .data_o(data_o),
        .ready_i(ready_i), .busy_o(busy_o), .seq_o(seq_o), .drop_count_o(drop_count_o));

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] beat(input int k);
        if (k < beats.size()) return beats[k];
        else return 32'hDEAD_BEEF;
    endfunction

    task automatic model_step();
        bit active, tick, trig;
        active = en_i && (interval_i != 0);
        tick   = active && (m_tmr >= longint'(interval_i) - 1);
        if (tick) m_tmr = 0;
        else if (active) m_tmr++;
        trig = en_i && (trigger_i || tick);
        if (mq.size() != 0) begin
            if (trig && m_drop != '1) m_drop++;
            if (ready_i) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_seq++;
            end
        end else if (trig) begin
            mq.push_back({8'hA5, 8'(ELS), m_seq});
            for (int i = 0; i < ELS; i++) mq.push_back(data_in[i]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset_i);
            if (reset_i) begin
                mq.delete();
                m_seq  = 16'd0;
                m_drop = '0;
                m_tmr  = 0;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison against the model, plus stall stability and beat logging.
    initial begin
        logic         pstall, pv, exp_v;
        logic [W-1:0] pd;
        pstall = 1'b0;
        pv     = 1'b0;
        pd     = '0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                pstall = 1'b0;
            end else begin
                exp_v = (mq.size() != 0);
                chk("v_o", W'(v_o), W'(exp_v));
                chk("data_o", data_o, exp_v ? mq[0] : '0);
                chk("busy_o", W'(busy_o), W'(exp_v));
                chk("seq_o", W'(seq_o), W'(m_seq));
                chk("drop_count_o", drop_count_o, m_drop);
                if (pstall) begin
                    chk("stall_v", W'(v_o), W'(pv));
                    chk("stall_data", data_o, pd);
                end
                pstall = v_o && !ready_i;
                pv     = v_o;
                pd     = data_o;
                if (v_o && ready_i) beats.push_back(data_o);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
        beats.delete();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((mq.size() != 0 || busy_o) && n < max_cyc) begin
            step();
            n++;
        end
        chk("wait_idle_bound", W'(n < max_cyc), W'(1));
    endtask

    initial begin
        int busy_n;
        int rises[$];
        bit prev_busy;
        logic [ELS-1:0][W-1:0] snap;
        int itab[5];
        int n;
        itab = '{0, 37, 90, 150, 5};
        en_i = 1'b0; trigger_i = 1'b0; ready_i = 1'b0; interval_i = '0; data_in = '0;
        step(); step(); step();
        reset_i = 1'b0;
        @(negedge clk);
        chk("reset_v", W'(v_o), 32'd0);
        chk("reset_data", data_o, 32'd0);
        chk("reset_busy", W'(busy_o), 32'd0);
        chk("reset_seq", W'(seq_o), 32'd0);
        chk("reset_drop", drop_count_o, 32'd0);
        step();

        // Basic packet: data[i] = i + 100.
        en_i = 1'b1; ready_i = 1'b1;
        for (int i = 0; i < ELS; i++) data_in[i] = W'(i + 100);
        beats.delete();
        trigger_i = 1'b1; step(); trigger_i = 1'b0;
        busy_n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy_o) busy_n++;
            step();
        end
        chk("t1_busy_cycles", W'(busy_n), 32'd76);
        chk("t1_beats", W'(beats.size()), 32'd76);
        chk("t1_header", beat(0), 32'hA54B_0000);
        chk("t1_first", beat(1), 32'd100);
        chk("t1_last", beat(75), 32'd174);
        chk("t1_seq", W'(seq_o), 32'd1);

        // Atomicity: counters ramp after the capture edge.
        for (int i = 0; i < ELS; i++) data_in[i] = W'(i * 3 + 5000);
        beats.delete();
        trigger_i = 1'b1; step(); trigger_i = 1'b0;
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < ELS; i++) data_in[i] = data_in[i] + 32'd1;
            step();
        end
        chk("atom_beats", W'(beats.size()), 32'd76);
        chk("atom_header", beat(0), 32'hA54B_0001);
        chk("atom_first", beat(1), 32'd5000);
        chk("atom_mid", beat(40), 32'd5117);
        chk("atom_last", beat(75), 32'd5222);

        // Drops at header+3 and last beat, capture right after, then reset at beat 40.
        apply_reset();
        for (int i = 0; i < ELS; i++) data_in[i] = $urandom;
        for (int c = 0; c < 118; c++) begin
            trigger_i = (c == 0 || c == 4 || c == 76 || c == 77);
            step();
        end
        trigger_i = 1'b0;
        chk("drop_count", drop_count_o, 32'd2);
        chk("drop_seq", W'(seq_o), 32'd1);
        chk("drop_second_header", beat(76), 32'hA54B_0001);
        chk("drop_beats", W'(beats.size()), 32'd116);
        chk("midreset_pre_v", W'(v_o), 32'd1);
        reset_i = 1'b1;
        #1;
        chk("midreset_v", W'(v_o), 32'd0);
        chk("midreset_data", data_o, 32'd0);
        chk("midreset_busy", W'(busy_o), 32'd0);
        chk("midreset_seq", W'(seq_o), 32'd0);
        chk("midreset_drop", drop_count_o, 32'd0);
        step(); step();
        reset_i = 1'b0;
        beats.delete();
        for (int k = 0; k < 60; k++) step();
        chk("midreset_no_tail", W'(beats.size()), 32'd0);

        // Periodic trigger every 200 cycles.
        apply_reset();
        interval_i = 32'd200;
        prev_busy = 1'b0;
        for (int k = 0; k < 1005; k++) begin
            @(negedge clk);
            if (busy_o && !prev_busy) rises.push_back(k);
            prev_busy = busy_o;
            step();
        end
        chk("periodic_packets", W'(rises.size()), 32'd5);
        for (int j = 1; j < rises.size(); j++) chk("periodic_gap", W'(rises[j] - rises[j-1]), 32'd200);
        chk("periodic_drop", drop_count_o, 32'd0);
        interval_i = '0;
        wait_idle(200);

        // Disabled: triggers and a short interval are ignored.
        en_i = 1'b0; interval_i = 32'd3;
        beats.delete();
        for (int c = 0; c < 40; c++) begin
            trigger_i = (c % 7 == 3);
            step();
        end
        trigger_i = 1'b0; interval_i = '0;
        chk("disabled_beats", W'(beats.size()), 32'd0);
        chk("disabled_drop", drop_count_o, 32'd0);
        en_i = 1'b1;

        // Backpressure with en_i dropped mid-packet.
        for (int i = 0; i < ELS; i++) data_in[i] = $urandom;
        snap = data_in;
        beats.delete();
        trigger_i = 1'b1; step(); trigger_i = 1'b0;
        n = 0;
        while (mq.size() != 0 && n < 3000) begin
            ready_i = ($urandom_range(0, 99) < 30);
            for (int i = 0; i < ELS; i++) data_in[i] = $urandom;
            if (n == 50) en_i = 1'b0;
            trigger_i = (n >= 50 && n <= 60);
            step();
            n++;
        end
        trigger_i = 1'b0; ready_i = 1'b1;
        wait_idle(200);
        en_i = 1'b1;
        chk("bp_beats", W'(beats.size()), 32'd76);
        chk("bp_header", beat(0), 32'hA54B_0005);
        chk("bp_first", beat(1), snap[0]);
        chk("bp_last", beat(75), snap[ELS-1]);
        chk("bp_drop", drop_count_o, 32'd0);
        chk("bp_seq", W'(seq_o), 32'd6);

        // Random soak against the model.
        for (int k = 0; k < 1500; k++) begin
            en_i      = ($urandom_range(0, 9) != 0);
            trigger_i = ($urandom_range(0, 19) == 0);
            ready_i   = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 99) == 0) interval_i = W'(itab[$urandom_range(0, 4)]);
            for (int i = 0; i < ELS; i++) data_in[i] = $urandom;
            step();
        end
        trigger_i = 1'b0; en_i = 1'b1; interval_i = '0; ready_i = 1'b1;
        wait_idle(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_profiler_snapshot.md
# bp_profiler_snapshot

Downstream consumer of the core commit/stall profiler counter array. On a software or periodic trigger it atomically captures all `els_p` counter words into a shadow array, then streams a header word followed by every captured counter, one word per handshake, toward the host-side readout FIFO. Counters that change after capture do not corrupt the packet. Triggers arriving mid-stream are counted and dropped.

## Interface
- `width_p`, 32: counter and output word width; must be >= 32.
- `els_p`, 75: number of counter words captured; must be 1..255.
- `interval_width_p`, 32: width of the periodic interval setting.

- `clk_i` in 1: sole clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `en_i` in 1: profiling enable. When 0, triggers are ignored and the interval timer holds.
- `data_i` in `[els_p-1:0][width_p-1:0]`: live counter array from the profiler.
- `trigger_i` in 1: one-cycle software snapshot request.
- `interval_i` in `interval_width_p`: periodic trigger period in cycles; 0 disables periodic triggers.
- `v_o` out 1: output word valid.
- `data_o` out `width_p`: output word.
- `ready_i` in 1: consumer ready. A beat transfers when `v_o & ready_i`.
- `busy_o` out 1: a snapshot is in progress (state != IDLE).
- `seq_o` out 16: count of completed packets; wraps at 2^16.
- `drop_count_o` out `width_p`: count of dropped triggers; saturates at all-ones.

## Operation
- **Trigger sources**
  - `trig = en_i & (trigger_i | tick)`.
  - `tick` pulses when the timer equals `interval_i-1` with `interval_i != 0`; the timer then returns to 0.
  - The timer counts +1 per cycle while `en_i` and `interval_i != 0`; otherwise it holds.
  - If `interval_i` is lowered below the current count, the comparison is `>=`, so the next tick fires immediately.
- **FSM states:** IDLE, HEADER, STREAM.
- **IDLE**
  - `v_o=0`.
  - On `trig`: shadow[i] <= `data_i[i]` for all i in the same edge; `idx` <= 0; go to HEADER.
- **HEADER**
  - `v_o=1`, `data_o = {zero-pad, 8'hA5, els_p[7:0], seq_o}`.
  - On handshake, go to STREAM.
- **STREAM**
  - `v_o=1`, `data_o = shadow[idx]`.
  - On handshake with `idx != els_p-1`: `idx++`.
  - On handshake with `idx == els_p-1`: `seq_o++` and go to IDLE.
- **Drops**
  - Any `trig` while in HEADER or STREAM increments `drop_count_o`, saturating.
  - This includes a `trig` in the cycle of the final handshake; that trigger is not captured.
- **`en_i` deasserted mid-packet:** the packet still completes, and no new triggers are accepted.
- **Stability:** `data_o` and `v_o` must hold stable while `v_o & ~ready_i`. Do not make `v_o` depend combinationally on `ready_i`.
- **Reset values:** state=IDLE, `v_o=0`, `data_o=0`, `busy_o=0`, `seq_o=0`, `drop_count_o=0`, timer=0, `idx=0`. Shadow contents are don't-care.
- **Reset mid-stream:** the packet is abandoned immediately, and no partial tail is emitted after reset.

## Timing
- Capture happens at the rising edge where `trig` is high in IDLE. The header is valid in the following cycle.
- A packet is `els_p+1` beats.
- With `ready_i` held high, trigger-to-IDLE takes `els_p+2` cycles and the next trigger is accepted in the cycle after the last beat.
- Each output beat has 1-cycle throughput. All outputs are registered or decoded from registered state and the shadow array; there is no combinational path from `data_i` to `data_o`.
- `busy_o` rises in the cycle after capture and falls in the cycle after the last handshake.

## Structure
- **Shared package `bp_profiler_pkg`:**
  - `bp_profiler_snapshot_state_e` (IDLE/HEADER/STREAM).
  - Header struct `{magic[7:0], count[7:0], seq[15:0]}`.
  - `localparam` magic byte 8'hA5.
- **Sub-module `bp_profiler_interval_timer`:** holds the timer and tick generation, with inputs `en_i` and `interval_i` and output `tick_o`.
- **Shadow array:** `bsg_dff_en` with the capture enable.

## Test plan
- `interval_i=0`, `data_i[i]=i+100`, single `trigger_i`, `ready_i=1`:
  - Header `0xA54B0000` appears 1 cycle later, then 100..174.
  - `seq_o=1` afterwards; `busy_o` is high for 76 cycles.
- Capture atomicity: after the trigger, ramp every `data_i` by 1 per cycle.
  - The streamed values equal the snapshot at the trigger edge.
- Backpressure: `ready_i` toggling at a random 30% duty cycle.
  - `data_o` and `v_o` stay stable while stalled; all 76 beats arrive in order exactly once.
- `interval_i=200`, `en_i=1`, `ready_i=1`, run for 1000 cycles:
  - Five packets, capture edges 200 cycles apart, `drop_count_o=0`.
- Drops: with `interval_i=0`, fire `trigger_i` at header +3, at the last-beat cycle, and 1 cycle after the last beat.
  - `drop_count_o=2`; the third trigger starts a second packet with header seq=1.
- Mid-stream: assert `reset_i` at beat 40.
  - `v_o=0` immediately and all counters read 0.
- Separately, with `en_i=0`, `trigger_i` pulses produce no packet and `drop_count_o` stays 0.
